// File: rtl/parc_rob_pkg.sv
// parc_rob_pkg: shared reorder-buffer definitions for the ROB controller
// and the datapath ROB storage (entry layout, default sizes, register zero).
package parc_rob_pkg;

    localparam int NUM_ENTRIES = 16;
    localparam int SLOT_W      = 4;
    localparam int RADDR_W     = 5;

    // Architectural r0 is hard-wired zero: never a real dependence.
    localparam logic [RADDR_W-1:0] REG_ZERO = '0;

    // Per-entry bookkeeping as seen by the datapath ROB storage.
    typedef struct packed {
        logic               valid;
        logic               filled;
        logic               wen;
        logic [RADDR_W-1:0] waddr;
    } rob_entry_t;

endpackage

// File: rtl/parc_rob_src_lookup.sv
// parc_rob_src_lookup: finds the youngest in-flight ROB entry writing a
// given source register, walking in age order starting at the head.
module parc_rob_src_lookup
    import parc_rob_pkg::*;
#(
    parameter int NUM_ENTRIES = parc_rob_pkg::NUM_ENTRIES,
    parameter int SLOT_W      = parc_rob_pkg::SLOT_W,
    parameter int RADDR_W     = parc_rob_pkg::RADDR_W
) (
    input  logic [NUM_ENTRIES-1:0]         valid_vec,
    input  logic [NUM_ENTRIES-1:0]         filled_vec,
    input  logic [NUM_ENTRIES-1:0]         wen_vec,
    input  logic [NUM_ENTRIES*RADDR_W-1:0] waddr_flat,
    input  logic [SLOT_W-1:0]              head,
    input  logic [RADDR_W-1:0]             src_addr,
    output logic                           pend,
    output logic                           ready,
    output logic [SLOT_W-1:0]              slot
);

    logic [SLOT_W-1:0] idx;

    // Age-ordered scan; a later (younger) match overrides an older one.
    always_comb begin
        pend  = 1'b0;
        ready = 1'b0;
        slot  = '0;
        idx   = '0;
        if (src_addr != RADDR_W'(REG_ZERO)) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                idx = head + SLOT_W'(i);
                if (valid_vec[idx] && wen_vec[idx] &&
                    (waddr_flat[int'(idx)*RADDR_W +: RADDR_W] == src_addr)) begin
                    pend  = 1'b1;
                    ready = filled_vec[idx];
                    slot  = idx;
                end
            end
        end
    end

endmodule

// File: rtl/parc_rob_ctrl.sv
// parc_rob_ctrl: in-order-retire reorder-buffer controller. Allocates at the
// tail, marks fills, retires one filled head entry per cycle and serves two
// source-operand lookups. Optional squash port enabled by PARC_ROB_FLUSH_EN.
module parc_rob_ctrl
    import parc_rob_pkg::*;
#(
    parameter int NUM_ENTRIES = parc_rob_pkg::NUM_ENTRIES,
    parameter int SLOT_W      = parc_rob_pkg::SLOT_W,
    parameter int RADDR_W     = parc_rob_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alloc_val,
    output logic               alloc_rdy,
    input  logic               alloc_wen,
    input  logic [RADDR_W-1:0] alloc_waddr,
    output logic [SLOT_W-1:0]  alloc_slot,
    input  logic               fill_val,
    input  logic [SLOT_W-1:0]  fill_slot,
    output logic               commit_val,
    output logic               commit_wen,
    output logic [SLOT_W-1:0]  commit_slot,
    output logic [RADDR_W-1:0] commit_waddr,
    input  logic [RADDR_W-1:0] src0_addr,
    input  logic [RADDR_W-1:0] src1_addr,
    output logic               src0_pend,
    output logic               src1_pend,
    output logic               src0_ready,
    output logic               src1_ready,
    output logic [SLOT_W-1:0]  src0_slot,
    output logic [SLOT_W-1:0]  src1_slot,
    output logic [SLOT_W:0]    count,
    output logic               empty,
    output logic               full
`ifdef PARC_ROB_FLUSH_EN
    ,
    input  logic               flush
`endif
);

    logic [NUM_ENTRIES-1:0] valid_q,  valid_d;
    logic [NUM_ENTRIES-1:0] filled_q, filled_d;
    logic [NUM_ENTRIES-1:0] wen_q,    wen_d;
    logic [RADDR_W-1:0]     waddr_q [NUM_ENTRIES];
    logic [RADDR_W-1:0]     waddr_d [NUM_ENTRIES];
    logic [SLOT_W-1:0]      head_q, head_d;
    logic [SLOT_W-1:0]      tail_q, tail_d;
    logic [SLOT_W:0]        count_q, count_d;
    logic [NUM_ENTRIES*RADDR_W-1:0] waddr_flat;
    logic                   alloc_fire;

    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == (SLOT_W+1)'(NUM_ENTRIES));
    assign alloc_slot = tail_q;
`ifdef PARC_ROB_FLUSH_EN
    assign alloc_rdy  = !full && !flush;
`else
    assign alloc_rdy  = !full;
`endif
    assign alloc_fire = alloc_val && alloc_rdy;

    assign commit_val   = valid_q[head_q] && filled_q[head_q];
    assign commit_wen   = commit_val && wen_q[head_q];
    assign commit_slot  = head_q;
    assign commit_waddr = waddr_q[head_q];

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_flat
            assign waddr_flat[gi*RADDR_W +: RADDR_W] = waddr_q[gi];
        end
    endgenerate

    // Next-state for entries and pointers: fill, retire, allocate, squash.
    always_comb begin
        valid_d  = valid_q;
        filled_d = filled_q;
        wen_d    = wen_q;
        waddr_d  = waddr_q;
        head_d   = head_q;
        tail_d   = tail_q;
        // A valid slot is never the tail while not full, so fill and
        // allocate never touch the same entry.
        if (fill_val && valid_q[fill_slot]) begin
            filled_d[fill_slot] = 1'b1;
        end
        if (commit_val) begin
            valid_d[head_q]  = 1'b0;
            filled_d[head_q] = 1'b0;
            head_d           = head_q + 1'b1;
        end
        if (alloc_fire) begin
            valid_d[tail_q]  = 1'b1;
            filled_d[tail_q] = 1'b0;
            wen_d[tail_q]    = alloc_wen && (alloc_waddr != RADDR_W'(REG_ZERO));
            waddr_d[tail_q]  = alloc_waddr;
            tail_d           = tail_q + 1'b1;
        end
        count_d = count_q + (SLOT_W+1)'(alloc_fire) - (SLOT_W+1)'(commit_val);
`ifdef PARC_ROB_FLUSH_EN
        // The head commit above still retires; everything else is dropped.
        if (flush) begin
            valid_d  = '0;
            filled_d = '0;
            head_d   = tail_q;
            tail_d   = tail_q;
            count_d  = '0;
        end
`endif
    end

    // State registers; reset discards every in-flight entry at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= '0;
            filled_q <= '0;
            wen_q    <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                waddr_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            filled_q <= filled_d;
            wen_q    <= wen_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            waddr_q  <= waddr_d;
        end
    end

    parc_rob_src_lookup #(
        .NUM_ENTRIES(NUM_ENTRIES), .SLOT_W(SLOT_W), .RADDR_W(RADDR_W)
    ) u_src0 (
        .valid_vec(valid_q), .filled_vec(filled_q), .wen_vec(wen_q),
        .waddr_flat(waddr_flat), .head(head_q), .src_addr(src0_addr),
        .pend(src0_pend), .ready(src0_ready), .slot(src0_slot)
    );

    parc_rob_src_lookup #(
        .NUM_ENTRIES(NUM_ENTRIES), .SLOT_W(SLOT_W), .RADDR_W(RADDR_W)
    ) u_src1 (
        .valid_vec(valid_q), .filled_vec(filled_q), .wen_vec(wen_q),
        .waddr_flat(waddr_flat), .head(head_q), .src_addr(src1_addr),
        .pend(src1_pend), .ready(src1_ready), .slot(src1_slot)
    );

endmodule

// File: tb/tb_parc_rob_ctrl.sv
// tb_parc_rob_ctrl: directed self-checking bench for parc_rob_ctrl.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_parc_rob_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       alloc_val = 1'b0;
    logic       alloc_rdy;
    logic       alloc_wen = 1'b0;
    logic [4:0] alloc_waddr = '0;
    logic [3:0] alloc_slot;
    logic       fill_val = 1'b0;
    logic [3:0] fill_slot = '0;
    logic       commit_val, commit_wen;
    logic [3:0] commit_slot;
    logic [4:0] commit_waddr;
    logic [4:0] src0_addr = '0, src1_addr = '0;
    logic       src0_pend, src1_pend, src0_ready, src1_ready;
    logic [3:0] src0_slot, src1_slot;
    logic [4:0] count;
    logic       empty, full;
`ifdef PARC_ROB_FLUSH_EN
    logic       flush = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    parc_rob_ctrl dut (
        .clk(clk), .reset(reset),
        .alloc_val(alloc_val), .alloc_rdy(alloc_rdy), .alloc_wen(alloc_wen),
        .alloc_waddr(alloc_waddr), .alloc_slot(alloc_slot),
        .fill_val(fill_val), .fill_slot(fill_slot),
        .commit_val(commit_val), .commit_wen(commit_wen),
        .commit_slot(commit_slot), .commit_waddr(commit_waddr),
        .src0_addr(src0_addr), .src1_addr(src1_addr),
        .src0_pend(src0_pend), .src1_pend(src1_pend),
        .src0_ready(src0_ready), .src1_ready(src1_ready),
        .src0_slot(src0_slot), .src1_slot(src1_slot),
        .count(count), .empty(empty), .full(full)
`ifdef PARC_ROB_FLUSH_EN
        , .flush(flush)
`endif
    );

    // One clock edge, landing on the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic do_alloc(input logic wen, input logic [4:0] a);
        alloc_val = 1'b1; alloc_wen = wen; alloc_waddr = a;
        step();
        alloc_val = 1'b0;
        $display("alloc wen=%0d waddr=%0d -> count=%0d", wen, a, count);
    endtask

    task automatic do_fill(input logic [3:0] s);
        fill_val = 1'b1; fill_slot = s;
        step();
        fill_val = 1'b0;
        $display("fill slot=%0d -> commit_val=%0d commit_slot=%0d", s, commit_val, commit_slot);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({alloc_rdy, alloc_slot, commit_val, commit_wen, commit_slot, commit_waddr,
             src0_pend, src0_ready, src0_slot, count, empty, full} !==
            {1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_outputs: rdy=%0d slot=%0d cval=%0d count=%0d empty=%0d full=%0d want 1 0 0 0 1 0",
                     alloc_rdy, alloc_slot, commit_val, count, empty, full);
        end
        @(negedge clk);
        reset = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        n_cmp++;
        if (alloc_slot !== 4'd0) begin n_bad++; $display("FAIL single_alloc_slot: got %0d want 0", alloc_slot); end
        do_alloc(1'b1, 5'd5);
        n_cmp++;
        if (count !== 5'd1 || commit_val !== 1'b0) begin
            n_bad++; $display("FAIL single_after_alloc: count=%0d cval=%0d want 1 0", count, commit_val);
        end
        do_fill(4'd0);
        n_cmp++;
        if ({commit_val, commit_wen, commit_waddr, commit_slot} !== {1'b1, 1'b1, 5'd5, 4'd0}) begin
            n_bad++; $display("FAIL single_commit: val=%0d wen=%0d waddr=%0d slot=%0d want 1 1 5 0",
                              commit_val, commit_wen, commit_waddr, commit_slot);
        end
        step();
        n_cmp++;
        if (empty !== 1'b1 || commit_val !== 1'b0) begin
            n_bad++; $display("FAIL single_empty: empty=%0d cval=%0d want 1 0", empty, commit_val);
        end
    endtask

    task automatic test_in_order();
        do_reset();
        for (int i = 0; i < 3; i++) do_alloc(1'b1, 5'(i + 1));
        do_fill(4'd2);
        do_fill(4'd1);
        n_cmp++;
        if (commit_val !== 1'b0) begin n_bad++; $display("FAIL inorder_hold: cval=%0d want 0", commit_val); end
        do_fill(4'd0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (commit_val !== 1'b1 || commit_slot !== 4'(i) || commit_waddr !== 5'(i + 1)) begin
                n_bad++; $display("FAIL inorder_commit%0d: val=%0d slot=%0d waddr=%0d want 1 %0d %0d",
                                  i, commit_val, commit_slot, commit_waddr, i, i + 1);
            end
            step();
        end
        n_cmp++;
        if (empty !== 1'b1) begin n_bad++; $display("FAIL inorder_empty: got %0d want 1", empty); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) do_alloc(1'b1, 5'(i));
        n_cmp++;
        if ({full, alloc_rdy, count} !== {1'b1, 1'b0, 5'd16}) begin
            n_bad++; $display("FAIL full_flags: full=%0d rdy=%0d count=%0d want 1 0 16", full, alloc_rdy, count);
        end
        do_alloc(1'b1, 5'd20);
        n_cmp++;
        if (count !== 5'd16) begin n_bad++; $display("FAIL full_reject: count=%0d want 16", count); end
        do_fill(4'd0);
        n_cmp++;
        if (commit_val !== 1'b1 || alloc_rdy !== 1'b0) begin
            n_bad++; $display("FAIL full_commit_rdy: cval=%0d rdy=%0d want 1 0", commit_val, alloc_rdy);
        end
        // Allocate attempt in the commit cycle must still be refused.
        do_alloc(1'b1, 5'd21);
        n_cmp++;
        if (count !== 5'd15 || alloc_slot !== 4'd0 || alloc_rdy !== 1'b1) begin
            n_bad++; $display("FAIL wrap_after_commit: count=%0d slot=%0d rdy=%0d want 15 0 1",
                              count, alloc_slot, alloc_rdy);
        end
        do_alloc(1'b1, 5'd15);
        n_cmp++;
        if (count !== 5'd16 || alloc_slot !== 4'd1 || commit_slot !== 4'd1) begin
            n_bad++; $display("FAIL wrap_alloc: count=%0d tail=%0d head=%0d want 16 1 1",
                              count, alloc_slot, commit_slot);
        end
        // r15 lives in slot 15 (older) and slot 0 (younger by age).
        src0_addr = 5'd15;
        #1;
        n_cmp++;
        if (src0_pend !== 1'b1 || src0_slot !== 4'd0) begin
            n_bad++; $display("FAIL wrap_youngest: pend=%0d slot=%0d want 1 0", src0_pend, src0_slot);
        end
        src0_addr = 5'd0;
    endtask

    task automatic test_lookup();
        do_reset();
        do_alloc(1'b1, 5'd7);
        do_alloc(1'b1, 5'd7);
        do_alloc(1'b1, 5'd3);
        src0_addr = 5'd7; src1_addr = 5'd0;
        #1;
        n_cmp++;
        if ({src0_pend, src0_slot, src0_ready} !== {1'b1, 4'd1, 1'b0}) begin
            n_bad++; $display("FAIL lookup_r7: pend=%0d slot=%0d ready=%0d want 1 1 0", src0_pend, src0_slot, src0_ready);
        end
        n_cmp++;
        if ({src1_pend, src1_ready, src1_slot} !== {1'b0, 1'b0, 4'd0}) begin
            n_bad++; $display("FAIL lookup_r0: pend=%0d ready=%0d slot=%0d want 0 0 0", src1_pend, src1_ready, src1_slot);
        end
        src1_addr = 5'd3;
        #1;
        n_cmp++;
        if ({src1_pend, src1_slot, src1_ready} !== {1'b1, 4'd2, 1'b0}) begin
            n_bad++; $display("FAIL lookup_r3: pend=%0d slot=%0d ready=%0d want 1 2 0", src1_pend, src1_slot, src1_ready);
        end
        do_fill(4'd1);
        n_cmp++;
        if (src0_ready !== 1'b1 || src0_slot !== 4'd1) begin
            n_bad++; $display("FAIL lookup_ready: ready=%0d slot=%0d want 1 1", src0_ready, src0_slot);
        end
        src0_addr = 5'd0; src1_addr = 5'd0;
    endtask

    task automatic test_nonwrite();
        do_reset();
        do_alloc(1'b0, 5'd9);
        do_alloc(1'b1, 5'd0);
        src0_addr = 5'd9;
        #1;
        n_cmp++;
        if (src0_pend !== 1'b0) begin n_bad++; $display("FAIL nowen_pend: got %0d want 0", src0_pend); end
        src0_addr = 5'd0;
        do_fill(4'd0);
        n_cmp++;
        if ({commit_val, commit_wen, commit_slot} !== {1'b1, 1'b0, 4'd0}) begin
            n_bad++; $display("FAIL nowen_commit: val=%0d wen=%0d slot=%0d want 1 0 0", commit_val, commit_wen, commit_slot);
        end
        do_fill(4'd1);
        n_cmp++;
        if ({commit_val, commit_wen, commit_slot} !== {1'b1, 1'b0, 4'd1}) begin
            n_bad++; $display("FAIL r0_commit: val=%0d wen=%0d slot=%0d want 1 0 1", commit_val, commit_wen, commit_slot);
        end
        step();
        n_cmp++;
        if (empty !== 1'b1) begin n_bad++; $display("FAIL nonwrite_empty: got %0d want 1", empty); end
    endtask

`ifdef PARC_ROB_FLUSH_EN
    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) do_alloc(1'b1, 5'(i + 1));
        do_fill(4'd0);
        flush = 1'b1; alloc_val = 1'b1; alloc_wen = 1'b1; alloc_waddr = 5'd9;
        #1;
        n_cmp++;
        if (commit_val !== 1'b1 || alloc_rdy !== 1'b0) begin
            n_bad++; $display("FAIL flush_cycle: cval=%0d rdy=%0d want 1 0", commit_val, alloc_rdy);
        end
        step();
        flush = 1'b0; alloc_val = 1'b0;
        $display("flush -> count=%0d empty=%0d", count, empty);
        n_cmp++;
        if ({count, empty, alloc_slot, commit_val} !== {5'd0, 1'b1, 4'd4, 1'b0}) begin
            n_bad++; $display("FAIL flush_after: count=%0d empty=%0d tail=%0d cval=%0d want 0 1 4 0",
                              count, empty, alloc_slot, commit_val);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_in_order();
        test_full_wrap();
        test_lookup();
        test_nonwrite();
`ifdef PARC_ROB_FLUSH_EN
        test_flush();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/parc_rob_ctrl.md
# parc_rob_ctrl

Reorder-buffer controller for the out-of-order PARCv2 core. It allocates ROB slots in program order at decode, records writeback fills, and retires entries strictly in order, one per cycle. It drives the ROB commit write-enable, slot and register address into the datapath, and gives decode per-source pending/ready/slot lookups for operand bypass out of the ROB.

## Interface
- `NUM_ENTRIES`, 16: ROB depth; must be a power of two.
- `SLOT_W`, 4: slot index width, log2(`NUM_ENTRIES`).
- `RADDR_W`, 5: architectural register address width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `alloc_val`  in  1  decode requests a slot.
- `alloc_rdy`  out  1  a slot is available.
- `alloc_wen`  in  1  the instruction writes a register.
- `alloc_waddr`  in  `RADDR_W`  destination register.
- `alloc_slot`  out  `SLOT_W`  slot granted (current tail).
- `fill_val`  in  1  writeback has deposited a result.
- `fill_slot`  in  `SLOT_W`  slot being filled.
- `commit_val`  out  1  head entry retires this cycle.
- `commit_wen`  out  1  retiring entry writes the register file.
- `commit_slot`  out  `SLOT_W`  head slot.
- `commit_waddr`  out  `RADDR_W`  head destination register.
- `src0_addr`, `src1_addr`  in  `RADDR_W`  decode source registers.
- `src0_pend`, `src1_pend`  out  1  an in-flight entry targets the source register.
- `src0_ready`, `src1_ready`  out  1  that entry is filled, so its value can be bypassed from the ROB.
- `src0_slot`, `src1_slot`  out  `SLOT_W`  the youngest matching slot.
- `count`  out  `SLOT_W`+1  number of occupied entries.
- `empty`, `full`  out  1  occupancy flags.
- `flush`  in  1  squash all entries; present only when `PARC_ROB_FLUSH_EN` is defined.

## Operation
- **Storage:** a circular buffer. Each entry holds `valid`, `filled`, `wen` and `waddr`. The controller keeps a head pointer, a tail pointer and a count.
- **Allocate:** fires on `alloc_val && alloc_rdy`. `alloc_rdy = !full`. The tail entry is written with `valid=1`, `filled=0`, `wen = alloc_wen && (alloc_waddr != 0)` and `waddr`. Then tail←tail+1 (wraps mod `NUM_ENTRIES`) and count increments.
- **Fill:** `fill_val` sets `filled` on `fill_slot` only if that entry is valid. A fill to an invalid slot is ignored, and a repeated fill is harmless.
- **Commit:**
  - `commit_val = valid[head] && filled[head]`.
  - `commit_wen = commit_val && wen[head]`.
  - `commit_slot = head`, `commit_waddr = waddr[head]`.
  - When `commit_val` is high, the entry is invalidated at the edge, head←head+1 and count decrements.
  - Non-writing entries (stores, branches) still retire with `commit_wen=0`.
- **Lookup:**
  - `srcN_pend` is 1 if any valid entry has `wen` set and `waddr == srcN_addr`.
  - `srcN_slot` is the youngest such entry in age order from head, not by slot index.
  - `srcN_ready` is `filled` of that entry.
  - Address 0 always gives pend=0, ready=0, slot=0.
  - Lookup reflects registered state only; it does not see same-cycle allocates or fills.
- **Simultaneous events:**
  - Allocate and commit in the same cycle: count is unchanged.
  - `alloc_rdy` is computed from the current count, so no allocate is accepted when full, even if a commit occurs that cycle.
  - A fill and commit may target different slots in the same cycle.
- **Reset (asserted low, asynchronous):**
  - State: head=tail=0, count=0, all `valid`/`filled` cleared.
  - Outputs: `alloc_rdy=1`, `alloc_slot=0`, `commit_val=0`, `commit_wen=0`, `commit_slot=0`, `commit_waddr=0`, all `srcN_*`=0, `count=0`, `empty=1`, `full=0`.
  - A reset during operation discards all entries immediately.

## Timing
- `commit_*`, `alloc_rdy`, `alloc_slot` and all lookup outputs are combinational from registered state, with no input-to-output paths except `srcN_addr` to the lookup outputs.
- Latency:
  - Allocate to earliest fill: next cycle.
  - Fill to commit: one cycle minimum (a fill at edge N enables `commit_val` during cycle N+1).
  - Allocate, fill, commit: at least 2 edges total.
- Throughput: one allocate, one fill and one commit per cycle.

## Configuration
- `PARC_ROB_FLUSH_EN` defined: the `flush` port exists.
  - On an edge with `flush=1`, a commit presented that cycle still retires.
  - All other entries are then invalidated, head←tail and count←0.
  - An allocate or fill in the same cycle is dropped, and `alloc_rdy` is forced 0 during flush.
- `PARC_ROB_FLUSH_EN` undefined: no `flush` port and no squash logic; entries leave only by commit.

## Structure
- **Shared package:** the ROB entry field layout, `NUM_ENTRIES`/`SLOT_W` defaults and the register-zero constant, which are also used by the datapath ROB storage.
- **Sub-module:** `parc_rob_src_lookup`, a youngest-match priority finder taking the entry vectors, head pointer and a source address. It is instantiated twice, once per source.

## Test plan
- **Reset and single instruction:** release reset; allocate `waddr=5` (slot 0); fill slot 0 one cycle later. Expect `commit_val=1`, `commit_wen=1`, `commit_waddr=5`, `commit_slot=0` on the following cycle, then `empty=1`.
- **In-order retirement:** allocate slots 0–2; fill slots 2 and 1. Expect no commit. Fill slot 0, then expect commits of slots 0, 1, 2 on three consecutive cycles.
- **Full and wrap:**
  - Allocate 16 entries with no fills: `full=1`, `alloc_rdy=0`, and a 17th `alloc_val` is not accepted.
  - Fill and commit slot 0, then allocate: granted slot 0, and the tail wraps.
- **Lookup:**
  - Allocate r7→slot 0, r7→slot 1, r3→slot 2. `src0_addr=7` gives pend=1, slot=1, ready=0.
  - Fill slot 1: ready=1.
  - `src1_addr=0` gives pend=0.
- **Non-writing and r0:** an allocate with `alloc_wen=0`, or with `waddr=0`, commits with `commit_val=1`, `commit_wen=0`.
- **Flush (`PARC_ROB_FLUSH_EN`):** with 4 entries and the head filled, assert `flush` together with `alloc_val`. Expect the head to commit that cycle, then `count=0`, `empty=1`, and the allocate dropped.
